// File: rtl/register_file_multi_port_write_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | register_file_multi_port_write_if : write/read/conflict bus of the         |
// | multi-write-port register file. Revision 1.0                               |
// +----------------------------------------------------------------------------+
interface register_file_multi_port_write_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_WRITE    = 2,
    parameter int CNT_WIDTH  = 16
) ();
    logic [N_WRITE-1:0]                 WriteEnable;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0] WriteAddr;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0] WriteData;
    logic                               ReadEnable;
    logic [ADDR_WIDTH-1:0]              ReadAddr;
    logic [DATA_WIDTH-1:0]              ReadData;
    logic                               ReadValid;
    logic                               WriteConflict;
    logic [CNT_WIDTH-1:0]               ConflictCount;
    logic                               ConflictClear;

    modport master (
        output WriteEnable, WriteAddr, WriteData, ReadEnable, ReadAddr, ConflictClear,
        input  ReadData, ReadValid, WriteConflict, ConflictCount
    );

    modport slave (
        input  WriteEnable, WriteAddr, WriteData, ReadEnable, ReadAddr, ConflictClear,
        output ReadData, ReadValid, WriteConflict, ConflictCount
    );
endinterface
`default_nettype wire

// File: rtl/register_file_multi_port_write.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | register_file_multi_port_write : N_WRITE-port register file, one registered|
// | read port, collision flag/counter. Optional macro RF_WRITE_BYPASS_EN.      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module register_file_multi_port_write #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_WRITE    = 2,
    parameter int N_ROWS     = 2**ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input wire logic clk,
    input wire logic rst_n,
    register_file_multi_port_write_if.slave rf_io
);
    localparam logic [ADDR_WIDTH:0] c_ROWS = (ADDR_WIDTH+1)'(N_ROWS);

    logic [DATA_WIDTH-1:0] mem_q [N_ROWS];
    logic [N_ROWS-1:0]     w_row_we;
    logic [DATA_WIDTH-1:0] w_row_wd [N_ROWS];
    logic                  w_conflict;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  conf_q,   conf_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < c_ROWS);
    endfunction

    // Ports scanned low to high, so the highest-index enabled port overrides.
    // Out-of-range addresses never match an implemented row and are dropped.
    always_comb begin
        for (int r = 0; r < N_ROWS; r++) begin
            w_row_we[r] = 1'b0;
            w_row_wd[r] = '0;
            for (int k = 0; k < N_WRITE; k++) begin
                if (rf_io.WriteEnable[k] && (rf_io.WriteAddr[k] == ADDR_WIDTH'(r))) begin
                    w_row_we[r] = 1'b1;
                    w_row_wd[r] = rf_io.WriteData[k];
                end
            end
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < N_WRITE; i++) begin
            for (int j = i + 1; j < N_WRITE; j++) begin
                if (rf_io.WriteEnable[i] && rf_io.WriteEnable[j] &&
                    (rf_io.WriteAddr[i] == rf_io.WriteAddr[j]) &&
                    addr_in_range(rf_io.WriteAddr[i])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Unmatched (out-of-range) read addresses fall through to zero.
    always_comb begin
        w_rd_word = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (rf_io.ReadAddr == ADDR_WIDTH'(r)) begin
`ifdef RF_WRITE_BYPASS_EN
                w_rd_word = w_row_we[r] ? w_row_wd[r] : mem_q[r];
`else
                w_rd_word = mem_q[r];
`endif
            end
        end
    end

    always_comb begin
        rdata_d  = rf_io.ReadEnable ? w_rd_word : rdata_q;
        rvalid_d = rf_io.ReadEnable;
        conf_d   = w_conflict;
        cnt_d    = cnt_q;
        if (rf_io.ConflictClear) begin
            cnt_d = '0;
        end else if (w_conflict && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_ROWS; r++) begin
                mem_q[r] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            conf_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            for (int r = 0; r < N_ROWS; r++) begin
                if (w_row_we[r]) begin
                    mem_q[r] <= w_row_wd[r];
                end
            end
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            conf_q   <= conf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rf_io.ReadData      = rdata_q;
    assign rf_io.ReadValid     = rvalid_q;
    assign rf_io.WriteConflict = conf_q;
    assign rf_io.ConflictCount = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_register_file_multi_port_write.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_register_file_multi_port_write : directed bench, 3 write ports,         |
// | 24 rows, 4-bit conflict counter. Revision 1.0                              |
// +----------------------------------------------------------------------------+
module tb_register_file_multi_port_write;
    localparam int c_AW = 5;
    localparam int c_DW = 32;
    localparam int c_NW = 3;
    localparam int c_NR = 24;
    localparam int c_CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   r_total = 0;
    int   r_pass  = 0;

    register_file_multi_port_write_if #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .N_WRITE(c_NW), .CNT_WIDTH(c_CW)
    ) rf ();

    register_file_multi_port_write #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .N_WRITE(c_NW),
        .N_ROWS(c_NR), .CNT_WIDTH(c_CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf_io (rf)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rf.WriteEnable   = '0;
        rf.WriteAddr     = '0;
        rf.WriteData     = '0;
        rf.ReadEnable    = 1'b0;
        rf.ReadAddr      = '0;
        rf.ConflictClear = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_row(input logic [c_AW-1:0] a, input logic [c_DW-1:0] exp, input string nm);
        idle();
        rf.ReadEnable = 1'b1;
        rf.ReadAddr   = a;
        step();
        r_total++;
        if (rf.ReadData !== exp || rf.ReadValid !== 1'b1)
            $display("FAIL %s addr %0d: got data %h valid %b, want data %h valid 1", nm, a, rf.ReadData, rf.ReadValid, exp);
        else r_pass++;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        r_total++;
        if (rf.ReadData !== '0 || rf.ReadValid !== 1'b0 || rf.WriteConflict !== 1'b0 || rf.ConflictCount !== '0)
            $display("FAIL reset_outputs: got %h %b %b %0d, want 0 0 0 0", rf.ReadData, rf.ReadValid, rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) read_row(c_AW'(a), 32'h0, "reset_row");
        idle();
        step();
        r_total++;
        if (rf.ReadValid !== 1'b0 || rf.WriteConflict !== 1'b0 || rf.ConflictCount !== 4'd0)
            $display("FAIL reset_idle: got valid %b conf %b cnt %0d, want 0 0 0", rf.ReadValid, rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
    endtask

    task automatic test_parallel_write();
        idle();
        rf.WriteEnable = 3'b011;
        rf.WriteAddr[0] = 5'd3;  rf.WriteData[0] = 32'hA5A5_0001;
        rf.WriteAddr[1] = 5'd7;  rf.WriteData[1] = 32'h5A5A_0002;
        step();
        r_total++;
        if (rf.WriteConflict !== 1'b0 || rf.ConflictCount !== 4'd0)
            $display("FAIL parallel_noconf: got conf %b cnt %0d, want 0 0", rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        read_row(5'd3, 32'hA5A5_0001, "parallel_row3");
        read_row(5'd7, 32'h5A5A_0002, "parallel_row7");
    endtask

    task automatic test_read_hold();
        idle();
        step();
        r_total++;
        if (rf.ReadData !== 32'h5A5A_0002 || rf.ReadValid !== 1'b0)
            $display("FAIL read_hold: got data %h valid %b, want 5a5a0002 0", rf.ReadData, rf.ReadValid);
        else r_pass++;
    endtask

    task automatic test_collision();
        idle();
        rf.WriteEnable = 3'b011;
        rf.WriteAddr[0] = 5'd9; rf.WriteData[0] = 32'h1111_1111;
        rf.WriteAddr[1] = 5'd9; rf.WriteData[1] = 32'h2222_2222;
        step();
        r_total++;
        if (rf.WriteConflict !== 1'b1 || rf.ConflictCount !== 4'd1)
            $display("FAIL collision_flag: got conf %b cnt %0d, want 1 1", rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        idle();
        step();
        r_total++;
        if (rf.WriteConflict !== 1'b0 || rf.ConflictCount !== 4'd1)
            $display("FAIL collision_pulse_end: got conf %b cnt %0d, want 0 1", rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        read_row(5'd9, 32'h2222_2222, "collision_row9");
        // port0 alone on row 11, ports 1 and 2 collide on row 12
        idle();
        rf.WriteEnable = 3'b111;
        rf.WriteAddr[0] = 5'd11; rf.WriteData[0] = 32'h0B0B_0B0B;
        rf.WriteAddr[1] = 5'd12; rf.WriteData[1] = 32'h1212_0001;
        rf.WriteAddr[2] = 5'd12; rf.WriteData[2] = 32'h1212_0002;
        step();
        r_total++;
        if (rf.WriteConflict !== 1'b1 || rf.ConflictCount !== 4'd2)
            $display("FAIL collision3_flag: got conf %b cnt %0d, want 1 2", rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        read_row(5'd11, 32'h0B0B_0B0B, "collision3_row11");
        read_row(5'd12, 32'h1212_0002, "collision3_row12");
    endtask

    task automatic test_read_during_write();
        logic [c_DW-1:0] exp;
`ifdef RF_WRITE_BYPASS_EN
        exp = 32'hDEAD_BEEF;
`else
        exp = 32'h0;
`endif
        idle();
        rf.WriteEnable = 3'b001;
        rf.WriteAddr[0] = 5'd5; rf.WriteData[0] = 32'hDEAD_BEEF;
        rf.ReadEnable = 1'b1;
        rf.ReadAddr   = 5'd5;
        step();
        r_total++;
        if (rf.ReadData !== exp || rf.ReadValid !== 1'b1)
            $display("FAIL rdw_row5: got data %h valid %b, want %h 1", rf.ReadData, rf.ReadValid, exp);
        else r_pass++;
        read_row(5'd5, 32'hDEAD_BEEF, "rdw_after");
    endtask

    task automatic test_saturation();
        idle();
        rf.WriteEnable = 3'b011;
        rf.WriteAddr[0] = 5'd1; rf.WriteData[0] = 32'h0000_0001;
        rf.WriteAddr[1] = 5'd1; rf.WriteData[1] = 32'h0000_0002;
        for (int i = 0; i < 20; i++) step();
        r_total++;
        if (rf.ConflictCount !== 4'd15 || rf.WriteConflict !== 1'b1)
            $display("FAIL saturate: got cnt %0d conf %b, want 15 1", rf.ConflictCount, rf.WriteConflict);
        else r_pass++;
        rf.ConflictClear = 1'b1;
        step();
        r_total++;
        if (rf.ConflictCount !== 4'd0 || rf.WriteConflict !== 1'b1)
            $display("FAIL clear_priority: got cnt %0d conf %b, want 0 1", rf.ConflictCount, rf.WriteConflict);
        else r_pass++;
        idle();
        step();
        r_total++;
        if (rf.ConflictCount !== 4'd0 || rf.WriteConflict !== 1'b0)
            $display("FAIL clear_idle: got cnt %0d conf %b, want 0 0", rf.ConflictCount, rf.WriteConflict);
        else r_pass++;
    endtask

    task automatic test_out_of_range();
        idle();
        rf.WriteEnable = 3'b011;
        rf.WriteAddr[0] = 5'd30; rf.WriteData[0] = 32'hFFFF_FFFF;
        rf.WriteAddr[1] = 5'd30; rf.WriteData[1] = 32'hFFFF_FFFF;
        step();
        r_total++;
        if (rf.WriteConflict !== 1'b0 || rf.ConflictCount !== 4'd0)
            $display("FAIL oor_noconf: got conf %b cnt %0d, want 0 0", rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        read_row(5'd30, 32'h0, "oor_read30");
        read_row(5'd23, 32'h0, "oor_lastrow");
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < 3; i++) begin
            rf.WriteEnable = 3'b100;
            rf.WriteAddr[2] = c_AW'(20 + i);
            rf.WriteData[2] = 32'hC0DE_0000 + 32'(i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            rf.ReadEnable = 1'b1;
            rf.ReadAddr   = c_AW'(20 + i);
            step();
            r_total++;
            if (rf.ReadData !== (32'hC0DE_0000 + 32'(i)) || rf.ReadValid !== 1'b1)
                $display("FAIL b2b_row%0d: got %h valid %b, want %h 1", 20 + i, rf.ReadData, rf.ReadValid, 32'hC0DE_0000 + 32'(i));
            else r_pass++;
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rf.WriteEnable = 3'b110;
        rf.WriteAddr[1] = 5'd4; rf.WriteData[1] = 32'h4444_0001;
        rf.WriteAddr[2] = 5'd4; rf.WriteData[2] = 32'h4444_0002;
        rf.ReadEnable = 1'b1;
        rf.ReadAddr   = 5'd3;
        step();
        r_total++;
        if (rf.ReadData !== 32'hA5A5_0001 || rf.WriteConflict !== 1'b1 || rf.ConflictCount !== 4'd1)
            $display("FAIL premid_state: got %h conf %b cnt %0d, want a5a50001 1 1", rf.ReadData, rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        #2 rst_n = 1'b0;
        #1;
        r_total++;
        if (rf.ReadData !== '0 || rf.ReadValid !== 1'b0 || rf.WriteConflict !== 1'b0 || rf.ConflictCount !== '0)
            $display("FAIL midreset_outputs: got %h %b %b %0d, want 0 0 0 0", rf.ReadData, rf.ReadValid, rf.WriteConflict, rf.ConflictCount);
        else r_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        read_row(5'd3, 32'h0, "midreset_row3");
        read_row(5'd4, 32'h0, "midreset_row4");
    endtask

    initial begin
        test_reset();
        test_parallel_write();
        test_read_hold();
        test_collision();
        test_read_during_write();
        test_saturation();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", r_pass, r_total);
        $finish;
    end
endmodule
`default_nettype wire
